gas_detector_array: RTL and testbench
=====================================

GAS_DETECTOR_ARRAY -- requirements
Module: gas_detector_array

Interface
REQ-001 The block SHALL expose parameter CHANNELS, default 4, the number of independent serial sensor channels.
REQ-002 The block SHALL expose parameter LEVEL_W, default 3, the width of each per-channel level word.
REQ-003 The block SHALL expose parameter WINDOW, default 7, the samples per measurement window (2..255).
REQ-004 The block SHALL expose parameter THRESH, default 5, the alarm level threshold.
REQ-005 The block SHALL expose parameter HOLD, default 2, the consecutive windows needed to enter or leave alarm (1..15).
REQ-006 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-007 The block SHALL have port arst, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port din, input, CHANNELS bits, one serial sample per channel per clock.
REQ-009 The block SHALL have port clr, input, 1 bit, alarm clear (used only under the latch option).
REQ-010 The block SHALL have port dout, output, CHANNELS*LEVEL_W bits, the per-channel level with channel c in bits [c*LEVEL_W +: LEVEL_W].
REQ-011 The block SHALL have port valid, output, 1 bit, a one-cycle pulse when dout/alarm are updated.
REQ-012 The block SHALL have port alarm, output, CHANNELS bits, the per-channel alarm.
REQ-013 The block SHALL have port any_alarm, output, 1 bit, the OR of alarm.

Function
REQ-014 A shared window counter k SHALL run 0..WINDOW-1 and wrap, starting at 0 on the first edge after reset release.
REQ-015 Each channel SHALL accumulate din[c]=1 samples; the accumulator width SHALL be clog2(WINDOW+1).
REQ-016 At the edge where k==WINDOW-1, the block SHALL load dout[c] with acc+din[c], saturated at 2^LEVEL_W-1, clear acc, and assert valid for exactly the following cycle.
REQ-017 Between window ends, dout and alarm SHALL hold their values.
REQ-018 Each channel SHALL run a 4-state FSM, IDLE/PEND/ALARM/CLEARING, evaluated only at window end using the new level L, with a per-channel run counter.
REQ-019 IDLE SHALL go to PEND (cnt=1) if L>=THRESH, or directly to ALARM if HOLD==1.
REQ-020 PEND SHALL go to IDLE if L<THRESH; otherwise it SHALL increment cnt and go to ALARM when cnt reaches HOLD.
REQ-021 ALARM SHALL go to CLEARING (cnt=1) if L<THRESH, or directly to IDLE if HOLD==1.
REQ-022 CLEARING SHALL return to ALARM if L>=THRESH; otherwise it SHALL increment cnt and go to IDLE when cnt reaches HOLD.
REQ-023 alarm[c] SHALL be registered and high exactly in states ALARM and CLEARING; alarm[c] and any_alarm SHALL update on the same edge as dout.
REQ-024 THRESH SHALL be compared against the saturated level; THRESH > 2^LEVEL_W-1 SHALL mean the alarm never asserts.

Reset
REQ-025 When arst is low, the block SHALL asynchronously force k=0, all acc=0, dout=0, valid=0, alarm=0, any_alarm=0, and all FSMs to IDLE with cnt=0.
REQ-026 Reset asserted mid-window SHALL discard the partial window; the first window after release SHALL contain exactly WINDOW fresh samples.

Configuration
REQ-027 With macro GAS_DETECTOR_LATCH_EN defined, ALARM SHALL NOT exit on low levels, CLEARING SHALL be unreachable, and clr=1 SHALL force every channel in ALARM to IDLE on the next edge.
REQ-028 With GAS_DETECTOR_LATCH_EN defined, clr coincident with a window end SHALL win, leaving the channel in IDLE regardless of L, while dout still updates.
REQ-029 Without GAS_DETECTOR_LATCH_EN, clr SHALL be ignored and the behaviour of REQ-021/022 SHALL apply.

Structure
REQ-030 Package gas_pkg SHALL hold the FSM state enum/encoding (2 bits), a saturate-to-LEVEL_W helper constant/function, and the default parameter values.
REQ-031 Per-channel logic (accumulator, saturation, FSM, alarm register) SHALL live in sub-module gas_channel, instantiated CHANNELS times with a shared window-end strobe from the top.

Verification (defaults: CHANNELS=4, LEVEL_W=3, WINDOW=7, THRESH=5, HOLD=2)
REQ-032 Reset release with din=4'b0000 for 14 cycles -> valid pulses after edges 7 and 14; dout=0; alarm=0.
REQ-033 din[0]=1 constantly, other channels 0 -> after window 1: dout[2:0]=7, alarm=0 (PEND); after window 2: alarm[0]=1, any_alarm=1.
REQ-034 Channel 1 in alarm, then a window with 4 ones followed by a window with 6 ones -> alarm[1] stays 1 (CLEARING then back to ALARM); two windows of 4 ones -> alarm[1]=0 after the second.
REQ-035 WINDOW=12 build, all ones -> dout saturates at 7, no wrap.
REQ-036 arst pulsed low at k=3 -> all outputs 0 immediately; the next valid appears exactly 7 edges after release.
REQ-037 GAS_DETECTOR_LATCH_EN build: alarm[2] set, then din=0 for 3 windows -> alarm stays 1; clr=1 on a window-end edge -> alarm[2]=0 next cycle, dout=0.

Source files
------------

// File: rtl/gas_pkg.sv
// -----------------------------------------------------------------------------
// gas_pkg
// Shared definitions for the gas detector array:
//   - default parameter values for the top level
//   - per-channel alarm FSM state encoding (2 bits)
//   - width of the per-channel run counter
//   - level saturation helper
// No ports (package).
// -----------------------------------------------------------------------------
package gas_pkg;

   localparam int DEF_CHANNELS = 4;
   localparam int DEF_LEVEL_W  = 3;
   localparam int DEF_WINDOW   = 7;
   localparam int DEF_THRESH   = 5;
   localparam int DEF_HOLD     = 2;

   // HOLD is limited to 1..15, so four bits cover the run counter.
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PEND     = 2'd1,
      ST_ALARM    = 2'd2,
      ST_CLEARING = 2'd3
   } gas_state_e;

   // Clamp a sample count to the largest value a level_w-bit word can hold.
   function automatic int unsigned sat_level(input int unsigned value,
                                             input int unsigned level_w);
      int unsigned max_level;
      max_level = (32'd1 << level_w) - 32'd1;
      return (value > max_level) ? max_level : value;
   endfunction

endpackage

// File: rtl/gas_channel.sv
// -----------------------------------------------------------------------------
// gas_channel
// One sensor channel: counts ones over a measurement window, publishes the
// saturated level at window end and runs the IDLE/PEND/ALARM/CLEARING
// debounce FSM on that level.
//
// Build option: GAS_DETECTOR_LATCH_EN -- ALARM is sticky (no exit on low
// levels) and clr_i returns a channel in ALARM to IDLE on the next edge.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   din_i      serial sample for this channel
//   win_end_i  shared strobe, high on the last sample of every window
//   clr_i      alarm clear (latch build only)
//   level_o    level of the last completed window
//   alarm_o    registered alarm (ALARM or CLEARING)
// -----------------------------------------------------------------------------
module gas_channel
   import gas_pkg::*;
#(
   parameter int LEVEL_W = DEF_LEVEL_W,
   parameter int WINDOW  = DEF_WINDOW,
   parameter int THRESH  = DEF_THRESH,
   parameter int HOLD    = DEF_HOLD
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               din_i,
   input  logic               win_end_i,
   input  logic               clr_i,
   output logic [LEVEL_W-1:0] level_o,
   output logic               alarm_o
);

   // Holds up to WINDOW ones, so the final sample can be added without wrap.
   localparam int ACC_W = $clog2(WINDOW + 1);

   logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
   logic [LEVEL_W-1:0] level_q, level_d, level_new;
   gas_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic               alarm_q, alarm_d;
   logic               hit;

   // Accumulator and level datapath.
   always_comb begin
      acc_sum   = acc_q + ACC_W'(din_i);
      level_new = LEVEL_W'(sat_level(32'(acc_sum), 32'(LEVEL_W)));
      // Compared in 32 bits so a threshold above the level range never hits.
      hit       = (int'(level_new) >= THRESH);
      acc_d     = win_end_i ? '0 : acc_sum;
      level_d   = win_end_i ? level_new : level_q;
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q   <= '0;
         level_q <= '0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         alarm_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         level_q <= level_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         alarm_q <= alarm_d;
      end
   end

   // Next-state logic, evaluated only at window end.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cnt_inc = cnt_q + CNT_W'(1);
      if (win_end_i) begin
         case (state_q)
            ST_IDLE: begin
               if (hit) begin
                  if (HOLD == 1) begin
                     state_d = ST_ALARM;
                     cnt_d   = '0;
                  end else begin
                     state_d = ST_PEND;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            ST_PEND: begin
               if (!hit) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cnt_inc == CNT_W'(HOLD)) begin
                  state_d = ST_ALARM;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_ALARM: begin
`ifdef GAS_DETECTOR_LATCH_EN
               state_d = ST_ALARM;
`else
               if (!hit) begin
                  if (HOLD == 1) begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = ST_CLEARING;
                     cnt_d   = CNT_W'(1);
                  end
               end
`endif
            end
            ST_CLEARING: begin
               if (hit) begin
                  state_d = ST_ALARM;
                  cnt_d   = '0;
               end else if (cnt_inc == CNT_W'(HOLD)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
`ifdef GAS_DETECTOR_LATCH_EN
      // Clear overrides any window-end decision for a latched channel.
      if (clr_i && (state_q == ST_ALARM)) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
`endif
   end

`ifndef GAS_DETECTOR_LATCH_EN
   logic unused_clr;
   assign unused_clr = clr_i;
`endif

   // Output logic: alarm follows the state being entered.
   always_comb begin
      alarm_d = (state_d == ST_ALARM) || (state_d == ST_CLEARING);
   end

   assign level_o = level_q;
   assign alarm_o = alarm_q;

endmodule

// File: rtl/gas_detector_array.sv
// -----------------------------------------------------------------------------
// gas_detector_array
// Array of CHANNELS serial gas sensors. A shared window counter marks the end
// of every WINDOW-sample measurement; each channel then publishes its
// saturated ones-count and updates its debounced alarm.
//
// Build option: GAS_DETECTOR_LATCH_EN -- latched alarms cleared by clr.
//
// Ports:
//   clk        rising-edge clock
//   arst       asynchronous active-low reset
//   din        one serial sample per channel per clock
//   clr        alarm clear (latch build only, ignored otherwise)
//   dout       per-channel level, channel c in [c*LEVEL_W +: LEVEL_W]
//   valid      one-cycle pulse following each window end
//   alarm      per-channel registered alarm
//   any_alarm  OR of alarm
// -----------------------------------------------------------------------------
module gas_detector_array
   import gas_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int LEVEL_W  = DEF_LEVEL_W,
   parameter int WINDOW   = DEF_WINDOW,
   parameter int THRESH   = DEF_THRESH,
   parameter int HOLD     = DEF_HOLD
) (
   input  logic                        clk,
   input  logic                        arst,
   input  logic [CHANNELS-1:0]         din,
   input  logic                        clr,
   output logic [CHANNELS*LEVEL_W-1:0] dout,
   output logic                        valid,
   output logic [CHANNELS-1:0]         alarm,
   output logic                        any_alarm
);

   localparam int K_W = $clog2(WINDOW);

   logic [K_W-1:0] k_q, k_d;
   logic           valid_q;
   logic           win_end;

   assign win_end = (k_q == K_W'(WINDOW - 1));

   always_comb begin
      k_d = win_end ? '0 : k_q + K_W'(1);
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         k_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         k_q     <= k_d;
         valid_q <= win_end;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      gas_channel #(
         .LEVEL_W (LEVEL_W),
         .WINDOW  (WINDOW),
         .THRESH  (THRESH),
         .HOLD    (HOLD)
      ) u_ch (
         .clk_i     (clk),
         .rst_ni    (arst),
         .din_i     (din[c]),
         .win_end_i (win_end),
         .clr_i     (clr),
         .level_o   (dout[c*LEVEL_W +: LEVEL_W]),
         .alarm_o   (alarm[c])
      );
   end

   assign valid     = valid_q;
   // OR of registered bits, so it changes on the same edge as alarm.
   assign any_alarm = |alarm;

endmodule

// File: tb/tb_gas_detector_array.sv
// -----------------------------------------------------------------------------
// tb_gas_detector_array
// Self-checking bench for gas_detector_array (default parameters) plus a
// WINDOW=12 instance for level saturation. A behavioural model pushes the
// expected levels/alarms at every window end; a monitor pops and compares
// them when valid is seen.
// -----------------------------------------------------------------------------
module tb_gas_detector_array;

   localparam int CH   = 4;
   localparam int LW   = 3;
   localparam int WIN  = 7;
   localparam int TH   = 5;
   localparam int HOLD = 2;
   localparam int LMAX = 7;

   localparam int M_IDLE  = 0;
   localparam int M_PEND  = 1;
   localparam int M_ALARM = 2;
   localparam int M_CLR   = 3;

   logic          clk  = 1'b0;
   logic          arst = 1'b1;
   logic          clr  = 1'b0;
   logic [3:0]    din  = 4'h0;
   logic [11:0]   dout;
   logic          valid;
   logic [3:0]    alarm;
   logic          any_alarm;

   logic [3:0]    din12 = 4'hF;
   logic [11:0]   dout12;
   logic          valid12;
   logic [3:0]    alarm12;
   logic          any12;

   gas_detector_array u_dut (
      .clk       (clk),
      .arst      (arst),
      .din       (din),
      .clr       (clr),
      .dout      (dout),
      .valid     (valid),
      .alarm     (alarm),
      .any_alarm (any_alarm)
   );

   gas_detector_array #(.WINDOW(12)) u_dut12 (
      .clk       (clk),
      .arst      (arst),
      .din       (din12),
      .clr       (1'b0),
      .dout      (dout12),
      .valid     (valid12),
      .alarm     (alarm12),
      .any_alarm (any12)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] lv;
      logic [3:0]  al;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_valid = 0;
   logic mon_en  = 1'b0;

   int   mk;
   int   macc [CH];
   int   mlev [CH];
   int   mst  [CH];
   int   mcnt [CH];
   logic exp_valid = 1'b0;

   function automatic logic [11:0] lev_vec();
      logic [11:0] v;
      v = '0;
      for (int i = 0; i < CH; i++) v[i*LW +: LW] = LW'(mlev[i]);
      return v;
   endfunction

   function automatic logic [3:0] al_vec();
      logic [3:0] v;
      for (int i = 0; i < CH; i++) v[i] = (mst[i] == M_ALARM) || (mst[i] == M_CLR);
      return v;
   endfunction

   task automatic model_reset();
      mk = 0;
      for (int i = 0; i < CH; i++) begin
         macc[i] = 0; mlev[i] = 0; mst[i] = M_IDLE; mcnt[i] = 0;
      end
      exp_valid = 1'b0;
      sbq.delete();
   endtask

   task automatic fsm_step(input int i, input bit hi);
      case (mst[i])
         M_IDLE:
            if (hi) begin
               if (HOLD == 1) mst[i] = M_ALARM;
               else begin mst[i] = M_PEND; mcnt[i] = 1; end
            end
         M_PEND:
            if (!hi) begin mst[i] = M_IDLE; mcnt[i] = 0; end
            else begin
               mcnt[i]++;
               if (mcnt[i] == HOLD) begin mst[i] = M_ALARM; mcnt[i] = 0; end
            end
         M_ALARM: begin
`ifndef GAS_DETECTOR_LATCH_EN
            if (!hi) begin
               if (HOLD == 1) mst[i] = M_IDLE;
               else begin mst[i] = M_CLR; mcnt[i] = 1; end
            end
`endif
         end
         default:
            if (hi) begin mst[i] = M_ALARM; mcnt[i] = 0; end
            else begin
               mcnt[i]++;
               if (mcnt[i] == HOLD) begin mst[i] = M_IDLE; mcnt[i] = 0; end
            end
      endcase
   endtask

   // Called right after a rising edge with the samples that edge consumed.
   task automatic model_edge(input logic [3:0] d);
      bit wend;
      int lvl;
      int prev;
      wend = (mk == WIN - 1);
      for (int i = 0; i < CH; i++) begin
         prev = mst[i];
         if (wend) begin
            lvl = macc[i] + int'(d[i]);
            if (lvl > LMAX) lvl = LMAX;
            mlev[i] = lvl;
            macc[i] = 0;
            fsm_step(i, lvl >= TH);
         end else begin
            macc[i] += int'(d[i]);
         end
`ifdef GAS_DETECTOR_LATCH_EN
         if (clr && prev == M_ALARM) begin mst[i] = M_IDLE; mcnt[i] = 0; end
`endif
      end
      if (wend) sbq.push_back(exp_t'({lev_vec(), al_vec()}));
      exp_valid = wend;
      mk = (mk + 1) % WIN;
   endtask

   task automatic cycle(input logic [3:0] d, input logic c);
      din = d;
      clr = c;
      @(posedge clk);
      model_edge(d);
      #1;
   endtask

   task automatic window(input logic [3:0] mask, input int ones);
      for (int s = 0; s < WIN; s++) cycle((s < ones) ? mask : 4'h0, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      arst = 1'b0;
      din  = 4'h0;
      clr  = 1'b0;
      model_reset();
      #1;
      arst = 1'b1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         n_tests++;
         if (valid !== exp_valid) begin
            n_fail++;
            $display("FAIL valid_pulse: got %b expected %b at %0t", valid, exp_valid, $time);
         end
         if (valid === 1'b1) begin
            n_valid++;
            n_tests++;
            if (sbq.size() == 0) begin
               n_fail++;
               $display("FAIL sb_underflow: valid with no expected window at %0t", $time);
            end else begin
               mon_e = sbq.pop_front();
               n_tests++;
               if ({dout, alarm, any_alarm} !== {mon_e.lv, mon_e.al, |mon_e.al}) begin
                  n_fail++;
                  $display("FAIL sb_window: got dout=%h alarm=%b any=%b expected dout=%h alarm=%b any=%b at %0t",
                           dout, alarm, any_alarm, mon_e.lv, mon_e.al, |mon_e.al, $time);
               end
            end
         end else begin
            n_tests++;
            if (dout !== lev_vec() || alarm !== al_vec() || any_alarm !== |al_vec()) begin
               n_fail++;
               $display("FAIL hold: got dout=%h alarm=%b any=%b expected dout=%h alarm=%b at %0t",
                        dout, alarm, any_alarm, lev_vec(), al_vec(), $time);
            end
         end
      end
   end

   task automatic test_reset();
      #1 arst = 1'b0;
      #1;
      n_tests++;
      if ({dout, valid, alarm, any_alarm} !== 18'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got dout=%h valid=%b alarm=%b any=%b expected all 0",
                  dout, valid, alarm, any_alarm);
      end
      n_tests++;
      if ({dout12, valid12, alarm12, any12} !== 18'h0) begin
         n_fail++;
         $display("FAIL reset_outputs12: got dout=%h valid=%b expected all 0", dout12, valid12);
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1 arst = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic test_idle();
      int n0;
      n0 = n_valid;
      repeat (14) cycle(4'h0, 1'b0);
      @(negedge clk);
      #1;
      n_tests++;
      if (n_valid - n0 != 2) begin
         n_fail++;
         $display("FAIL idle_valid_count: got %0d expected 2", n_valid - n0);
      end
      n_tests++;
      if (dout !== 12'h0 || alarm !== 4'h0) begin
         n_fail++;
         $display("FAIL idle_levels: got dout=%h alarm=%b expected 0/0", dout, alarm);
      end
   endtask

   task automatic test_single_channel();
      do_reset();
      window(4'b0001, WIN);
      n_tests++;
      if (dout[2:0] !== 3'd7 || alarm !== 4'h0) begin
         n_fail++;
         $display("FAIL single_win1: got lvl=%0d alarm=%b expected 7/0000", dout[2:0], alarm);
      end
      window(4'b0001, WIN);
      n_tests++;
      if (alarm !== 4'b0001 || any_alarm !== 1'b1) begin
         n_fail++;
         $display("FAIL single_win2: got alarm=%b any=%b expected 0001/1", alarm, any_alarm);
      end
   endtask

   task automatic test_clearing();
      do_reset();
      window(4'b0010, WIN);
      window(4'b0010, WIN);
      n_tests++;
      if (alarm[1] !== 1'b1) begin
         n_fail++; $display("FAIL clear_enter: got %b expected 1", alarm[1]);
      end
      window(4'b0010, 4);
      n_tests++;
      if (alarm[1] !== 1'b1 || dout[5:3] !== 3'd4) begin
         n_fail++; $display("FAIL clear_low1: got alarm=%b lvl=%0d expected 1/4", alarm[1], dout[5:3]);
      end
      window(4'b0010, 6);
      n_tests++;
      if (alarm[1] !== 1'b1 || dout[5:3] !== 3'd6) begin
         n_fail++; $display("FAIL clear_back: got alarm=%b lvl=%0d expected 1/6", alarm[1], dout[5:3]);
      end
      window(4'b0010, 4);
      n_tests++;
      if (alarm[1] !== 1'b1) begin
         n_fail++; $display("FAIL clear_low2a: got %b expected 1", alarm[1]);
      end
      window(4'b0010, 4);
      n_tests++;
      if (alarm[1] !== 1'b0 || any_alarm !== 1'b0) begin
         n_fail++; $display("FAIL clear_exit: got alarm=%b any=%b expected 0/0", alarm[1], any_alarm);
      end
   endtask

   task automatic test_threshold();
      do_reset();
      repeat (2) begin
         for (int s = 0; s < WIN; s++) cycle({(s < 4), (s < 5), 2'b00}, 1'b0);
      end
      n_tests++;
      if (alarm !== 4'b0100 || dout[8:6] !== 3'd5 || dout[11:9] !== 3'd4) begin
         n_fail++;
         $display("FAIL threshold_edge: got alarm=%b lv2=%0d lv3=%0d expected 0100/5/4",
                  alarm, dout[8:6], dout[11:9]);
      end
   endtask

   task automatic test_clr();
      do_reset();
      window(4'b0100, WIN);
      window(4'b0100, WIN);
`ifdef GAS_DETECTOR_LATCH_EN
      repeat (3) window(4'b0000, 0);
      n_tests++;
      if (alarm[2] !== 1'b1 || dout[8:6] !== 3'd0) begin
         n_fail++; $display("FAIL latch_hold: got alarm=%b lvl=%0d expected 1/0", alarm[2], dout[8:6]);
      end
      for (int s = 0; s < WIN; s++) cycle(4'h0, (s == WIN - 1));
      n_tests++;
      if (alarm[2] !== 1'b0 || dout[8:6] !== 3'd0 || any_alarm !== 1'b0) begin
         n_fail++; $display("FAIL latch_clr: got alarm=%b any=%b expected 0/0", alarm[2], any_alarm);
      end
`else
      for (int s = 0; s < WIN; s++) cycle(4'h0, 1'b1);
      n_tests++;
      if (alarm[2] !== 1'b1) begin
         n_fail++; $display("FAIL clr_ignored1: got %b expected 1", alarm[2]);
      end
      for (int s = 0; s < WIN; s++) cycle(4'h0, 1'b1);
      n_tests++;
      if (alarm[2] !== 1'b0) begin
         n_fail++; $display("FAIL clr_ignored2: got %b expected 0", alarm[2]);
      end
`endif
   endtask

   task automatic test_async_reset();
      int found;
      do_reset();
      window(4'hF, WIN);
      window(4'hF, WIN);
      repeat (3) cycle(4'hF, 1'b0);
      arst = 1'b0;
      #1;
      n_tests++;
      if ({dout, valid, alarm, any_alarm} !== 18'h0) begin
         n_fail++;
         $display("FAIL async_reset: got dout=%h valid=%b alarm=%b any=%b expected all 0",
                  dout, valid, alarm, any_alarm);
      end
      model_reset();
      #1 arst = 1'b1;
      found = 0;
      for (int i = 1; i <= 20; i++) begin
         cycle(4'h0, 1'b0);
         if (valid === 1'b1) begin
            found = i;
            break;
         end
      end
      n_tests++;
      if (found != WIN) begin
         n_fail++; $display("FAIL async_restart: valid after %0d edges expected %0d", found, WIN);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int w = 0; w < 6; w++) begin
         for (int s = 0; s < WIN; s++) cycle(4'($urandom_range(0, 15)), 1'b0);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (sbq.size() != 0) begin
         n_fail++; $display("FAIL sb_leftover: got %0d pending windows expected 0", sbq.size());
      end
   endtask

   task automatic test_saturation();
      int found;
      do_reset();
      found = 0;
      for (int i = 1; i <= 30; i++) begin
         cycle(4'h0, 1'b0);
         if (valid12 === 1'b1) begin
            found = i;
            break;
         end
      end
      n_tests++;
      if (found != 12) begin
         n_fail++; $display("FAIL sat_latency: valid12 after %0d edges expected 12", found);
      end
      n_tests++;
      if (dout12 !== 12'hFFF || alarm12 !== 4'h0) begin
         n_fail++; $display("FAIL sat_win1: got dout=%h alarm=%b expected fff/0000", dout12, alarm12);
      end
      repeat (12) cycle(4'h0, 1'b0);
      n_tests++;
      if (dout12 !== 12'hFFF || alarm12 !== 4'hF || any12 !== 1'b1) begin
         n_fail++; $display("FAIL sat_win2: got dout=%h alarm=%b any=%b expected fff/1111/1",
                            dout12, alarm12, any12);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_channel();
      test_clearing();
      test_threshold();
      test_clr();
      test_async_reset();
      test_random();
      test_saturation();
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
